bcd_down_counter: RTL

- Synchronous, cascadable, multi-digit BCD down counter.
- Down-counting counterpart of the decade up-counter already in the library.
- Pin behaviour follows the 74-series style: synchronous active-low LOAD, count enables ENP/ENT, and a ripple borrow output BO that drives the next stage's ENT.
- Used for preset countdown timers and for the decrementing side of up/down counter pairs.

---
 rtl/bcd_down_counter.sv | 65 ++++++
 1 files changed

// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter (74-series style: CLR, LOAD, ENP/ENT, BO).
// Latency: load/count take effect on the next CLK edge; CLR clears Q immediately; BO is combinational.
// Backpressure: none; ENP/ENT gate the count and BO feeds the next stage's ENT.
// Optional: define BCD_DOWN_HOLD_AT_ZERO_EN for one-shot mode (Q sticks at zero instead of wrapping).
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  ENP,
    input  logic                  ENT,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  BO
);

    logic [4*DIGITS-1:0] q_q;
    logic [4*DIGITS-1:0] q_d;
    logic [4*DIGITS-1:0] dec_val;
    logic [DIGITS:0]     zero_below;
    logic                all_zero;

    assign zero_below[0] = 1'b1;

    // A digit decrements only when every lower digit is zero; invalid codes snap to 9 and do not borrow.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] digit;
        logic [3:0] digit_dec;

        assign digit           = q_q[4*k +: 4];
        assign digit_dec       = (digit == 4'd0 || digit > 4'd9) ? 4'd9 : digit - 4'd1;
        assign dec_val[4*k +: 4] = zero_below[k] ? digit_dec : digit;
        assign zero_below[k+1] = zero_below[k] & (digit == 4'd0);
    end

    assign all_zero = zero_below[DIGITS];

    always_comb begin
        q_d = q_q;
        if (!LOAD) begin
            q_d = D;
        end else if (ENP && ENT) begin
`ifdef BCD_DOWN_HOLD_AT_ZERO_EN
            if (!all_zero) begin
                q_d = dec_val;
            end
`else
            q_d = dec_val;
`endif
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign BO = ENT & all_zero;

endmodule
